// File: rtl/time_pkg.sv
// time_pkg: shared types and constants for the H:M:S counter.
//   mode_t        - mode FSM state (RUN=0, SET_H=1, SET_M=2, SET_S=3)
//   DEF_MOD_*     - default field moduli
//   cw()          - register width for a modulus, never below 1 bit
//   to_bcd()      - two-digit BCD of a value below 100 (used with BCD_OUT_EN)
package time_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} mode_t;
    localparam int DEF_MOD_S = 60;
    localparam int DEF_MOD_M = 60;
    localparam int DEF_MOD_H = 24;
    function automatic int cw(int m);
        return m > 1 ? $clog2(m) : 1;
    endfunction
    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
endpackage

// File: rtl/count_mod.sv
// count_mod: modulo-MOD up-counter for one time field.
//   clk   - clock, rising edge
//   set_s - asynchronous active-low reset to 0
//   inc   - advance by one this cycle
//   value - current field value
//   wrap  - combinational: inc while at MOD-1 (this edge returns to 0)
module count_mod
    import time_pkg::*;
#(
    parameter int MOD = DEF_MOD_S,
    parameter int W   = cw(MOD)
) (
    input  logic         clk,
    input  logic         set_s,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);
    assign wrap = inc && value == W'(MOD - 1);

    always_ff @(posedge clk or negedge set_s) begin
        if (!set_s)
            value <= '0;
        else if (inc)
            value <= wrap ? '0 : value + 1'b1;
    end
endmodule

// File: rtl/time_count_hms.sv
// time_count_hms: hours:minutes:seconds counter with prescaler and set-mode FSM.
//   clk        - clock, rising edge
//   set_s      - asynchronous active-low reset
//   en         - run enable (effective in RUN only)
//   mode_btn   - advance RUN->SET_H->SET_M->SET_S->RUN, one step per cycle high
//   inc_btn    - in SET_x, increment the selected field (no carry)
//   cnt_s/m/h  - field values
//   pulse_min/hour/day - registered one-cycle carry strobes
//   mode       - current FSM state
//   bcd_s/m/h  - BCD view of the fields, present only with BCD_OUT_EN defined
module time_count_hms
    import time_pkg::*;
#(
    parameter int MOD_S    = DEF_MOD_S,
    parameter int MOD_M    = DEF_MOD_M,
    parameter int MOD_H    = DEF_MOD_H,
    parameter int TICK_DIV = 1
) (
    input  logic                     clk,
    input  logic                     set_s,
    input  logic                     en,
    input  logic                     mode_btn,
    input  logic                     inc_btn,
    output logic [$clog2(MOD_S)-1:0] cnt_s,
    output logic [$clog2(MOD_M)-1:0] cnt_m,
    output logic [$clog2(MOD_H)-1:0] cnt_h,
    output logic                     pulse_min,
    output logic                     pulse_hour,
    output logic                     pulse_day,
    output logic [1:0]               mode
`ifdef BCD_OUT_EN
    ,
    output logic [7:0]               bcd_s,
    output logic [7:0]               bcd_m,
    output logic [7:0]               bcd_h
`endif
);
    localparam int PW = cw(TICK_DIV);

    mode_t         state, state_nxt;
    logic [PW-1:0] pre;
    logic          tick, set_inc;
    logic          inc_s, inc_m, inc_h;
    logic          wrap_s, wrap_m, wrap_h;

    always_ff @(posedge clk or negedge set_s) begin
        if (!set_s)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = mode_btn ? mode_t'(state + 2'd1) : state;
        tick      = state == RUN && en && pre == PW'(TICK_DIV - 1);
        // a simultaneous mode press swallows the increment
        set_inc   = inc_btn && !mode_btn;
        inc_s     = tick || (state == SET_S && set_inc);
        // in SET states wraps must not cascade, so carries only flow in RUN
        inc_m     = state == RUN ? wrap_s : state == SET_M && set_inc;
        inc_h     = state == RUN ? wrap_m : state == SET_H && set_inc;
    end

    always_ff @(posedge clk or negedge set_s) begin
        if (!set_s)
            pre <= '0;
        else if (state != RUN)
            pre <= '0;
        else if (en)
            pre <= tick ? '0 : pre + 1'b1;
    end

    // tick gating keeps set-mode wraps from producing strobes
    always_ff @(posedge clk or negedge set_s) begin
        if (!set_s) begin
            pulse_min  <= 1'b0;
            pulse_hour <= 1'b0;
            pulse_day  <= 1'b0;
        end else begin
            pulse_min  <= tick && wrap_s;
            pulse_hour <= tick && wrap_m;
            pulse_day  <= tick && wrap_h;
        end
    end

    count_mod #(.MOD(MOD_S), .W($clog2(MOD_S))) u_s (
        .clk(clk), .set_s(set_s), .inc(inc_s), .value(cnt_s), .wrap(wrap_s)
    );
    count_mod #(.MOD(MOD_M), .W($clog2(MOD_M))) u_m (
        .clk(clk), .set_s(set_s), .inc(inc_m), .value(cnt_m), .wrap(wrap_m)
    );
    count_mod #(.MOD(MOD_H), .W($clog2(MOD_H))) u_h (
        .clk(clk), .set_s(set_s), .inc(inc_h), .value(cnt_h), .wrap(wrap_h)
    );

    assign mode = state;

`ifdef BCD_OUT_EN
    assign bcd_s = to_bcd(int'(cnt_s));
    assign bcd_m = to_bcd(int'(cnt_m));
    assign bcd_h = to_bcd(int'(cnt_h));
`endif
endmodule
